sample_info_fetcher: RTL and testbench

// - Upstream feeder of the sample DMA requester. Walks the active voices in ascending ID order.
// - For each active voice, reads its playback pointers from the sample-info BRAM.
// - Presents {addr, id, valid, overflow, last} to the requester and holds them until load_next_sample.
// - Writes the advanced read pointer back to BRAM for every voice that was not overflowed.
// - Pulses voice_done when a voice has exhausted its sample data.

---
 rtl/sample_info_fetcher.sv | 277 +++++++++++++++++++++++++++
 tb/tb_sample_info_fetcher.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_info_fetcher.sv
// sample_info_fetcher
// Walks the active voices in ascending id order, reads each voice's playback
// pointers from the sample-info BRAM and presents them to the DMA requester.
// Voices that still have data get their read pointer advanced by one request
// worth of bytes and written back; exhausted voices are reported through a
// one-cycle voice_done pulse instead.
//
// All outputs are registered. A strobe such as bram_rd_en or bram_wr_en is
// therefore set on the transition into the state it belongs to. It is visible
// for exactly the first cycle of that state.

module sample_info_fetcher #(
  parameter  int NUM_VOICES   = 64,
  parameter  int BRAM_LATENCY = 2,
  parameter  int REQ_BYTES    = 256,
  localparam int ID_W         = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_VOICES-1:0] voice_active_mask,
  output logic [ID_W-1:0]       bram_addr,
  output logic                  bram_rd_en,
  input  logic [63:0]           bram_rd_data,
  output logic                  bram_wr_en,
  output logic [31:0]           bram_wr_data,
  output logic [31:0]           sample_addr,
  output logic [ID_W-1:0]       sample_id,
  output logic                  sample_valid,
  output logic                  sample_overflow,
  output logic                  sample_last,
  input  logic                  load_next_sample,
  input  logic                  all_samples_invalid,
  output logic                  voice_done_valid,
  output logic [ID_W-1:0]       voice_done_id,
  output logic                  round_restart
);

  // FSM encoding
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEEK      = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_PRESENT   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;

  // Cycle count of READ at which the BRAM data is valid. The first READ cycle
  // carries the read strobe and counts as 0.
  localparam logic [2:0]  LAT_CNT   = 3'(BRAM_LATENCY);
  localparam logic [31:0] REQ_STEP  = 32'(REQ_BYTES);

  // Internal state
  logic [2:0]      state_q, state_d;
  logic            scan_vld_q, scan_vld_d;   // 0 = scan pointer is "none"
  logic [ID_W-1:0] scan_id_q, scan_id_d;
  logic [2:0]      rd_cnt_q, rd_cnt_d;

  // Registered outputs
  logic [ID_W-1:0] bram_addr_q, bram_addr_d;
  logic            bram_rd_en_q, bram_rd_en_d;
  logic            bram_wr_en_q, bram_wr_en_d;
  logic [31:0]     bram_wr_data_q, bram_wr_data_d;
  logic [31:0]     sample_addr_q, sample_addr_d;
  logic [ID_W-1:0] sample_id_q, sample_id_d;
  logic            sample_valid_q, sample_valid_d;
  logic            sample_overflow_q, sample_overflow_d;
  logic            sample_last_q, sample_last_d;
  logic            voice_done_valid_q, voice_done_valid_d;
  logic [ID_W-1:0] voice_done_id_q, voice_done_id_d;
  logic            round_restart_q, round_restart_d;

  // Search results
  logic            scan_none;
  logic            higher_found;
  logic [ID_W-1:0] higher_id;
  logic            lowest_found;
  logic [ID_W-1:0] lowest_id;
  logic            any_above;

  // BRAM word fields
  logic [31:0] rd_curr_addr;
  logic [31:0] rd_end_addr;

  assign rd_curr_addr = bram_rd_data[31:0];
  assign rd_end_addr  = bram_rd_data[63:32];

  // all_samples_invalid restarts the scan in the same cycle it is seen.
  assign scan_none = !scan_vld_q || all_samples_invalid;

  // Priority search: lowest active id overall and lowest active id past the
  // scan pointer. The loop runs downwards, so the last hit is the lowest id.
  always_comb begin
    // NOTE: every variable assigned in a combinational block receives a
    // default first; a path that leaves one unassigned would infer a latch.
    higher_found = 1'b0;
    higher_id    = '0;
    lowest_found = 1'b0;
    lowest_id    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_active_mask[i]) begin
        lowest_found = 1'b1;
        lowest_id    = ID_W'(i);
        if (scan_none || (ID_W'(i) > scan_id_q)) begin
          higher_found = 1'b1;
          higher_id    = ID_W'(i);
        end
      end
    end
  end

  // sample_last: is any active voice above the one being read?
  always_comb begin
    any_above = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_active_mask[i] && (ID_W'(i) > bram_addr_q)) begin
        any_above = 1'b1;
      end
    end
  end

  // Next-state and output computation
  always_comb begin
    state_d            = state_q;
    scan_vld_d         = scan_vld_q;
    scan_id_d          = scan_id_q;
    rd_cnt_d           = rd_cnt_q;
    bram_addr_d        = bram_addr_q;
    bram_wr_data_d     = bram_wr_data_q;
    sample_addr_d      = sample_addr_q;
    sample_id_d        = sample_id_q;
    sample_valid_d     = sample_valid_q;
    sample_overflow_d  = sample_overflow_q;
    sample_last_d      = sample_last_q;
    voice_done_id_d    = voice_done_id_q;
    // Strobes and pulses last a single cycle unless re-armed below.
    bram_rd_en_d       = 1'b0;
    bram_wr_en_d       = 1'b0;
    voice_done_valid_d = 1'b0;
    round_restart_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        scan_vld_d = 1'b0;
        if (enable) state_d = S_SEEK;
      end

      S_SEEK: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          if (all_samples_invalid) scan_vld_d = 1'b0;
          // With an empty mask the fetcher keeps searching here.
          if (lowest_found) begin
            // No voice past the pointer means the round wraps to the lowest id.
            // A "none" pointer always finds one, so it never pulses.
            round_restart_d = !higher_found;
            scan_id_d       = higher_found ? higher_id : lowest_id;
            bram_addr_d     = higher_found ? higher_id : lowest_id;
            scan_vld_d      = 1'b1;
            bram_rd_en_d    = 1'b1;
            rd_cnt_d        = '0;
            state_d         = S_READ;
          end
        end
      end

      S_READ: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (all_samples_invalid) begin
          scan_vld_d = 1'b0;
          state_d    = S_SEEK;
        end else if (rd_cnt_q == LAT_CNT) begin
          sample_addr_d     = rd_curr_addr;
          sample_id_d       = bram_addr_q;
          sample_overflow_d = (rd_curr_addr >= rd_end_addr);
          sample_last_d     = !any_above;
          sample_valid_d    = 1'b1;
          state_d           = S_PRESENT;
        end else begin
          rd_cnt_d = rd_cnt_q + 3'd1;
        end
      end

      S_PRESENT: begin
        if (!enable) begin
          sample_valid_d = 1'b0;
          state_d        = S_IDLE;
        end else if (all_samples_invalid) begin
          // Abandon the entry. The pointer stays put and no voice_done pulse
          // is sent.
          sample_valid_d = 1'b0;
          scan_vld_d     = 1'b0;
          state_d        = S_SEEK;
        end else if (load_next_sample) begin
          sample_valid_d = 1'b0;
          if (sample_overflow_q) begin
            voice_done_valid_d = 1'b1;
            voice_done_id_d    = sample_id_q;
            state_d            = S_SEEK;
          end else begin
            // The pointer wraps modulo 2^32.
            bram_wr_en_d   = 1'b1;
            bram_addr_d    = sample_id_q;
            bram_wr_data_d = sample_addr_q + REQ_STEP;
            state_d        = S_WRITEBACK;
          end
        end
      end

      S_WRITEBACK: begin
        // The write strobe is already on the bus during this cycle. Neither
        // enable nor all_samples_invalid can cancel it.
        if (all_samples_invalid) scan_vld_d = 1'b0;
        state_d = enable ? S_SEEK : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments, so every flop samples
    // the values from before the edge no matter how the statements are ordered.
    if (reset) begin
      state_q            <= S_IDLE;
      scan_vld_q         <= 1'b0;
      scan_id_q          <= '0;
      rd_cnt_q           <= '0;
      bram_addr_q        <= '0;
      bram_rd_en_q       <= 1'b0;
      bram_wr_en_q       <= 1'b0;
      bram_wr_data_q     <= '0;
      sample_addr_q      <= '0;
      sample_id_q        <= '0;
      sample_valid_q     <= 1'b0;
      sample_overflow_q  <= 1'b0;
      sample_last_q      <= 1'b0;
      voice_done_valid_q <= 1'b0;
      voice_done_id_q    <= '0;
      round_restart_q    <= 1'b0;
    end else begin
      state_q            <= state_d;
      scan_vld_q         <= scan_vld_d;
      scan_id_q          <= scan_id_d;
      rd_cnt_q           <= rd_cnt_d;
      bram_addr_q        <= bram_addr_d;
      bram_rd_en_q       <= bram_rd_en_d;
      bram_wr_en_q       <= bram_wr_en_d;
      bram_wr_data_q     <= bram_wr_data_d;
      sample_addr_q      <= sample_addr_d;
      sample_id_q        <= sample_id_d;
      sample_valid_q     <= sample_valid_d;
      sample_overflow_q  <= sample_overflow_d;
      sample_last_q      <= sample_last_d;
      voice_done_valid_q <= voice_done_valid_d;
      voice_done_id_q    <= voice_done_id_d;
      round_restart_q    <= round_restart_d;
    end
  end

  assign bram_addr        = bram_addr_q;
  assign bram_rd_en       = bram_rd_en_q;
  assign bram_wr_en       = bram_wr_en_q;
  assign bram_wr_data     = bram_wr_data_q;
  assign sample_addr      = sample_addr_q;
  assign sample_id        = sample_id_q;
  assign sample_valid     = sample_valid_q;
  assign sample_overflow  = sample_overflow_q;
  assign sample_last      = sample_last_q;
  assign voice_done_valid = voice_done_valid_q;
  assign voice_done_id    = voice_done_id_q;
  assign round_restart    = round_restart_q;

endmodule

// File: tb/tb_sample_info_fetcher.sv
// tb_sample_info_fetcher
// Directed bench for sample_info_fetcher. It contains a BRAM model and a
// requester that loads the next sample two cycles after each presentation.
// The stimulus pushes the expected presentations, writes and voice_done
// events into queues. An independent monitor pops and compares them.

module tb_sample_info_fetcher;

  localparam int NV  = 64;
  localparam int LAT = 2;
  localparam int IDW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [NV-1:0]   voice_active_mask;
  logic [IDW-1:0]  bram_addr;
  logic            bram_rd_en;
  logic [63:0]     bram_rd_data;
  logic            bram_wr_en;
  logic [31:0]     bram_wr_data;
  logic [31:0]     sample_addr;
  logic [IDW-1:0]  sample_id;
  logic            sample_valid;
  logic            sample_overflow;
  logic            sample_last;
  logic            load_next_sample;
  logic            all_samples_invalid;
  logic            voice_done_valid;
  logic [IDW-1:0]  voice_done_id;
  logic            round_restart;

  always #5 clk = ~clk;

  sample_info_fetcher #(
    .NUM_VOICES  (NV),
    .BRAM_LATENCY(LAT),
    .REQ_BYTES   (256)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .voice_active_mask  (voice_active_mask),
    .bram_addr          (bram_addr),
    .bram_rd_en         (bram_rd_en),
    .bram_rd_data       (bram_rd_data),
    .bram_wr_en         (bram_wr_en),
    .bram_wr_data       (bram_wr_data),
    .sample_addr        (sample_addr),
    .sample_id          (sample_id),
    .sample_valid       (sample_valid),
    .sample_overflow    (sample_overflow),
    .sample_last        (sample_last),
    .load_next_sample   (load_next_sample),
    .all_samples_invalid(all_samples_invalid),
    .voice_done_valid   (voice_done_valid),
    .voice_done_id      (voice_done_id),
    .round_restart      (round_restart)
  );

  // Scoreboard
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    addr;
    logic           ov;
    logic           last;
    logic           rr;    // round_restart pulse seen since the previous presentation
  } pres_t;

  typedef struct packed {
    logic [IDW-1:0] addr;
    logic [31:0]    data;
  } wr_t;

  pres_t          exp_pres[$];
  wr_t            exp_wr[$];
  logic [IDW-1:0] exp_done[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_pres(input logic [IDW-1:0] id, input logic [31:0] addr,
                           input logic ov, input logic last, input logic rr);
    exp_pres.push_back('{id: id, addr: addr, ov: ov, last: last, rr: rr});
  endtask

  task automatic push_wr(input logic [IDW-1:0] addr, input logic [31:0] data);
    exp_wr.push_back('{addr: addr, data: data});
  endtask

  // BRAM model with a read latency of LAT cycles
  logic [63:0] mem  [NV];
  logic [63:0] pipe [LAT];

  always @(posedge clk) begin
    pipe[0] <= bram_rd_en ? mem[bram_addr] : 64'h0;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    if (bram_wr_en) mem[bram_addr][31:0] <= bram_wr_data;
  end

  assign bram_rd_data = pipe[LAT-1];

  task automatic set_entry(input int idx, input logic [31:0] end_a, input logic [31:0] curr_a);
    mem[idx] <= {end_a, curr_a};
  endtask

  // Requester: loads the next sample two cycles after a presentation, as long
  // as load_budget allows
  int load_budget = 0;
  int vcnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      load_next_sample = 1'b0;
      vcnt = 0;
    end else if (load_next_sample) begin
      load_next_sample = 1'b0;
    end else if (sample_valid && load_budget > 0) begin
      if (vcnt == 2) begin
        load_next_sample = 1'b1;
        load_budget--;
        vcnt = 0;
      end else begin
        vcnt++;
      end
    end else begin
      vcnt = 0;
    end
  end

  // Monitor: compares presentations, write-backs and voice_done pulses
  logic  prev_valid = 1'b0;
  logic  rr_seen = 1'b0;
  int    pres_count = 0;
  pres_t held;
  pres_t e_p;
  wr_t   e_w;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      rr_seen    = 1'b0;
    end else begin
      if (round_restart) rr_seen = 1'b1;

      if (sample_valid && !prev_valid) begin
        if (exp_pres.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_present: got id %0d addr 0x%0h, nothing expected",
                   sample_id, sample_addr);
        end else begin
          e_p = exp_pres.pop_front();
          check("present_id", 64'(sample_id), 64'(e_p.id));
          check("present_addr", 64'(sample_addr), 64'(e_p.addr));
          check("present_overflow", 64'(sample_overflow), 64'(e_p.ov));
          check("present_last", 64'(sample_last), 64'(e_p.last));
          check("round_restart_before_present", 64'(rr_seen), 64'(e_p.rr));
        end
        held = '{id: sample_id, addr: sample_addr, ov: sample_overflow,
                 last: sample_last, rr: 1'b0};
        rr_seen = 1'b0;
        pres_count++;
      end else if (sample_valid) begin
        check("present_hold", {23'h0, sample_id, sample_addr, sample_overflow, sample_last},
              {23'h0, held.id, held.addr, held.ov, held.last});
      end
      prev_valid = sample_valid;

      if (bram_wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, nothing expected",
                   bram_addr, bram_wr_data);
        end else begin
          e_w = exp_wr.pop_front();
          check("write_addr", 64'(bram_addr), 64'(e_w.addr));
          check("write_data", 64'(bram_wr_data), 64'(e_w.data));
        end
      end

      if (voice_done_valid) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_voice_done: got id %0d, nothing expected", voice_done_id);
        end else begin
          check("voice_done_id", 64'(voice_done_id), 64'(exp_done.pop_front()));
        end
      end
    end
  end

  // Stimulus helpers
  task automatic wait_pres(input int n, input string name);
    int t = 0;
    while (pres_count < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(pres_count >= n), 64'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_bram_outputs"},
          {24'h0, bram_addr, bram_rd_en, bram_wr_en, bram_wr_data}, 64'h0);
    check({name, "_sample_outputs"},
          {15'h0, sample_addr, sample_id, sample_valid, sample_overflow, sample_last,
           voice_done_valid, voice_done_id, round_restart}, 64'h0);
  endtask

  task automatic end_phase(input string name);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check({name, "_valid_dropped"}, 64'(sample_valid), 64'd0);
    check({name, "_present_queue_empty"}, 64'(exp_pres.size()), 64'd0);
    check({name, "_write_queue_empty"}, 64'(exp_wr.size()), 64'd0);
    check({name, "_done_queue_empty"}, 64'(exp_done.size()), 64'd0);
  endtask

  // Stop the run if it hangs somewhere unexpected
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    int busy;

    reset = 1'b1;
    enable = 1'b0;
    voice_active_mask = '0;
    load_next_sample = 1'b0;
    all_samples_invalid = 1'b0;
    for (int i = 0; i < NV; i++) mem[i] <= 64'h0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Phase 1: mask 0x15, one full round, then the first voice of round 2
    set_entry(0, 32'h2000, 32'h1000);
    set_entry(2, 32'h2000, 32'h1000);
    set_entry(4, 32'h2000, 32'h1000);
    voice_active_mask = 64'h15;
    load_budget = 3;
    push_pres(0, 32'h1000, 1'b0, 1'b0, 1'b0);
    push_wr(0, 32'h1100);
    push_pres(2, 32'h1000, 1'b0, 1'b0, 1'b0);
    push_wr(2, 32'h1100);
    push_pres(4, 32'h1000, 1'b0, 1'b1, 1'b0);
    push_wr(4, 32'h1100);
    push_pres(0, 32'h1100, 1'b0, 1'b0, 1'b1);
    base = pres_count;
    @(negedge clk);
    enable = 1'b1;
    wait_pres(base + 4, "p1_presentations");
    end_phase("p1");
    check("p1_mem0", 64'(mem[0][31:0]), 64'h1100);
    check("p1_mem2", 64'(mem[2][31:0]), 64'h1100);
    check("p1_mem4", 64'(mem[4][31:0]), 64'h1100);

    // Phase 2: voice 3 is exhausted (curr == end)
    set_entry(3, 32'h2000, 32'h2000);
    voice_active_mask = 64'h08;
    load_budget = 1;
    push_pres(3, 32'h2000, 1'b1, 1'b1, 1'b0);
    exp_done.push_back(6'd3);
    push_pres(3, 32'h2000, 1'b1, 1'b1, 1'b1);
    base = pres_count;
    @(negedge clk);
    enable = 1'b1;
    wait_pres(base + 2, "p2_presentations");
    end_phase("p2");
    check("p2_mem3_untouched", 64'(mem[3][31:0]), 64'h2000);

    // Phase 3: voice 5 read pointer wraps past 2^32
    set_entry(5, 32'hFFFF_FFFF, 32'hFFFF_FF80);
    voice_active_mask = 64'h20;
    load_budget = 1;
    push_pres(5, 32'hFFFF_FF80, 1'b0, 1'b1, 1'b0);
    push_wr(5, 32'h0000_0080);
    push_pres(5, 32'h0000_0080, 1'b0, 1'b1, 1'b1);
    base = pres_count;
    @(negedge clk);
    enable = 1'b1;
    wait_pres(base + 2, "p3_presentations");
    end_phase("p3");
    check("p3_mem5", 64'(mem[5][31:0]), 64'h0000_0080);

    // Phase 4: enable drops during the WRITEBACK cycle
    set_entry(0, 32'h2000, 32'h1000);
    set_entry(2, 32'h2000, 32'h1000);
    set_entry(4, 32'h2000, 32'h1000);
    voice_active_mask = 64'h15;
    load_budget = 1;
    push_pres(0, 32'h1000, 1'b0, 1'b0, 1'b0);
    push_wr(0, 32'h1100);
    @(negedge clk);
    enable = 1'b1;
    t = 0;
    while (!bram_wr_en && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("p4_writeback_seen", 64'(bram_wr_en), 64'd1);
    enable = 1'b0;
    busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (bram_rd_en || sample_valid || bram_wr_en) busy++;
    end
    check("p4_idle_after_writeback", 64'(busy), 64'd0);
    check("p4_mem0_written", 64'(mem[0][31:0]), 64'h1100);
    push_pres(0, 32'h1100, 1'b0, 1'b0, 1'b0);
    base = pres_count;
    enable = 1'b1;
    wait_pres(base + 1, "p4_reenable_presentation");
    end_phase("p4");

    // Phase 5: all_samples_invalid while voice 9 is presented
    set_entry(2, 32'h2000, 32'h1000);
    set_entry(9, 32'h3000, 32'h2000);
    set_entry(20, 32'h4000, 32'h3000);
    voice_active_mask = (64'h1 << 2) | (64'h1 << 9) | (64'h1 << 20);
    load_budget = 1;
    push_pres(2, 32'h1000, 1'b0, 1'b0, 1'b0);
    push_wr(2, 32'h1100);
    push_pres(9, 32'h2000, 1'b0, 1'b0, 1'b0);
    push_pres(2, 32'h1100, 1'b0, 1'b0, 1'b0);
    base = pres_count;
    @(negedge clk);
    enable = 1'b1;
    wait_pres(base + 2, "p5_voice9_presented");
    @(negedge clk);
    all_samples_invalid = 1'b1;
    @(negedge clk);
    all_samples_invalid = 1'b0;
    wait_pres(base + 3, "p5_restart_presentation");
    end_phase("p5");
    check("p5_mem9_untouched", 64'(mem[9][31:0]), 64'h2000);

    // Phase 6: reset asserted in the middle of READ
    set_entry(0, 32'h2000, 32'h1000);
    voice_active_mask = 64'h15;
    load_budget = 0;
    @(negedge clk);
    enable = 1'b1;
    t = 0;
    while (!bram_rd_en && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("p6_read_seen", 64'(bram_rd_en), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outputs_zero("p6_reset");
    push_pres(0, 32'h1000, 1'b0, 1'b0, 1'b0);
    base = pres_count;
    @(negedge clk);
    reset = 1'b0;
    wait_pres(base + 1, "p6_restart_presentation");
    end_phase("p6");
    check("p6_mem0_untouched", 64'(mem[0][31:0]), 64'h1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
